// File: rtl/wb2core_if.sv
// Bus bundles for the Wishbone-to-core bridge: Wishbone B4 pipelined
// slave side and Ibex-style req/gnt/rvalid memory port.
interface wb_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat_m;
  logic [31:0] dat_s;
  logic        ack;
  logic        err;
  logic        stall;

  modport master (output cyc, stb, we, sel, adr, dat_m,
                  input  dat_s, ack, err, stall);
  modport slave  (input  cyc, stb, we, sel, adr, dat_m,
                  output dat_s, ack, err, stall);
endinterface

interface core_if;
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (output req, we, be, addr, wdata,
                  input  gnt, rvalid, rdata, err);
  modport slave  (input  req, we, be, addr, wdata,
                  output gnt, rvalid, rdata, err);
endinterface

// File: rtl/wb2core.sv
// Wishbone B4 pipelined slave driving a core-style memory port. Requests pass
// straight through; responses are registered and orphaned ones are drained.
module wb2core #(
  parameter int MaxOutstanding = 4,
  parameter int CntWidth       = $clog2(MaxOutstanding + 1)
) (
  input  logic   clk,
  input  logic   rst_n,
  wb_if.slave    wb,
  core_if.master core,
  output logic   protocol_err
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACTIVE = 2'd1;
  localparam logic [1:0] DRAIN  = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [CntWidth-1:0] count_q, count_d;
  logic                ack_q, err_q;
  logic [31:0]         dat_s_q;

  logic full, wb_req, accept, rv_counted, rsp_fwd;

  assign full       = (count_q == CntWidth'(MaxOutstanding));
  assign wb_req     = wb.cyc & wb.stb;
  assign accept     = core.req & core.gnt;
  // a response with nothing outstanding is never counted or forwarded
  assign rv_counted = core.rvalid & (count_q != '0);
  assign rsp_fwd    = rv_counted & (state_q != DRAIN) & wb.cyc;

  assign core.req   = wb_req & ~full & (state_q != DRAIN);
  assign core.addr  = wb.adr;
  assign core.we    = wb.we;
  assign core.be    = wb.sel;
  assign core.wdata = wb.dat_m;

  assign wb.stall = wb_req ? ~accept : (state_q == DRAIN);
  assign wb.ack   = ack_q;
  assign wb.err   = err_q;
  assign wb.dat_s = dat_s_q;

  always_comb begin
    count_d = count_q;
    case ({accept, rv_counted})
      2'b10:   count_d = count_q + CntWidth'(1);
      2'b01:   count_d = count_q - CntWidth'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (wb.cyc) state_d = ACTIVE;
      ACTIVE:  if (!wb.cyc) state_d = (count_d == '0) ? IDLE : DRAIN;
      DRAIN:   if (count_d == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      count_q      <= '0;
      ack_q        <= 1'b0;
      err_q        <= 1'b0;
      dat_s_q      <= '0;
      protocol_err <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      ack_q        <= rsp_fwd & ~core.err;
      err_q        <= rsp_fwd & core.err;
      if (rsp_fwd) dat_s_q <= core.rdata;
      protocol_err <= protocol_err | (core.rvalid & (count_q == '0));
    end
  end

endmodule

// File: tb/tb_wb2core.sv
// Self-checking bench for wb2core: vector table, directed corner sequences
// and a randomized run against an outstanding-count reference model.
module tb_wb2core;
  localparam int MaxOut = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic protocol_err;

  always #5 clk = ~clk;

  wb_if   wb();
  core_if core();

  wb2core #(.MaxOutstanding(MaxOut)) dut (
    .clk(clk), .rst_n(rst_n), .wb(wb), .core(core), .protocol_err(protocol_err)
  );

  int checks = 0;
  int errors = 0;
  logic s_stall, s_req, a_ack, a_err;
  logic [31:0] a_dat;
  int rvk, nack;

  typedef struct {
    logic c, s, g, r, e;
    logic [31:0] adr, rdata;
    logic x_stall, x_req, x_ack, x_err;
    logic [31:0] x_dat;
  } tv_t;

  tv_t tv [8];

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle: comb outputs sampled mid-cycle, registered ones after the edge.
  task automatic step(input logic c, s, w, g, r, e, input logic [31:0] adr, rd);
    wb.cyc = c; wb.stb = s; wb.we = w; wb.adr = adr; wb.sel = 4'hF; wb.dat_m = ~adr;
    core.gnt = g; core.rvalid = r; core.err = e; core.rdata = rd;
    #1;
    s_stall = wb.stall;
    s_req   = core.req;
    @(posedge clk); #1;
    a_ack = wb.ack;
    a_err = wb.err;
    a_dat = wb.dat_s;
  endtask

  task automatic idle_inputs();
    wb.cyc = 0; wb.stb = 0; wb.we = 0; wb.adr = '0; wb.sel = '0; wb.dat_m = '0;
    core.gnt = 0; core.rvalid = 0; core.err = 0; core.rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  // Empty bridge: exactly MaxOut accepts before stall, then drain with cyc low.
  task automatic probe_empty(input string tag);
    for (int i = 0; i <= MaxOut; i++) begin
      step(1, 1, 1, 1, 0, 0, 32'h200 + 32'(i * 4), 32'h0);
      chk1({tag, "_stall"}, s_stall, i == MaxOut);
    end
    for (int i = 0; i < MaxOut; i++) begin
      step(0, 0, 0, 0, 1, 0, 32'h0, 32'(i));
      chk1({tag, "_drain_ack"}, a_ack, 1'b0);
    end
    step(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    chk1({tag, "_idle_stall"}, s_stall, 1'b0);
  endtask

  task automatic pw(input logic s, r, x_stall);
    logic [31:0] rd;
    rd = 32'hA0 + 32'(rvk);
    step(1, s, 1, 1, r, 0, 32'h300, rd);
    if (s) chk1("pw_stall", s_stall, x_stall);
    if (r) rvk++;
    chk1("pw_ack", a_ack, r);
    if (a_ack) begin
      nack++;
      chk32("pw_order", a_dat, rd);
    end
  endtask

  initial begin
    int pend;
    bit drn;
    logic [31:0] edat;
    logic c, s, g, r, e, req, acc, resp;
    logic [31:0] rd;

    tv[0] = '{0,0,0,0,0, 32'h0,   32'h0,        0,0,0,0, 32'h0};
    tv[1] = '{1,1,1,0,0, 32'h100, 32'h0,        0,1,0,0, 32'h0};
    tv[2] = '{1,0,0,1,0, 32'h104, 32'hDEADBEEF, 0,0,1,0, 32'hDEADBEEF};
    tv[3] = '{1,0,0,0,0, 32'h108, 32'h0,        0,0,0,0, 32'hDEADBEEF};
    tv[4] = '{1,1,0,0,0, 32'h10C, 32'h0,        1,1,0,0, 32'hDEADBEEF};
    tv[5] = '{1,1,1,0,0, 32'h10C, 32'h0,        0,1,0,0, 32'hDEADBEEF};
    tv[6] = '{1,0,0,1,1, 32'h110, 32'h1234,     0,0,0,1, 32'h1234};
    tv[7] = '{0,0,0,0,0, 32'h0,   32'h0,        0,0,0,0, 32'h1234};

    do_reset();
    chk1("rst_ack", wb.ack, 1'b0);
    chk1("rst_err", wb.err, 1'b0);
    chk32("rst_dat", wb.dat_s, 32'h0);
    chk1("rst_perr", protocol_err, 1'b0);
    chk1("rst_stall", wb.stall, 1'b0);
    chk1("rst_req", core.req, 1'b0);

    // single read, stalled request, error response
    for (int i = 0; i < 8; i++) begin
      step(tv[i].c, tv[i].s, 1'b0, tv[i].g, tv[i].r, tv[i].e, tv[i].adr, tv[i].rdata);
      chk1("tv_stall", s_stall, tv[i].x_stall);
      chk1("tv_req", s_req, tv[i].x_req);
      chk32("tv_addr", core.addr, tv[i].adr);
      chk32("tv_wdata", core.wdata, ~tv[i].adr);
      chk1("tv_ack", a_ack, tv[i].x_ack);
      chk1("tv_err", a_err, tv[i].x_err);
      chk32("tv_dat", a_dat, tv[i].x_dat);
    end

    // pipelined writes with back-pressure at MaxOut
    rvk = 0; nack = 0;
    repeat (MaxOut) pw(1, 0, 0);
    pw(1, 1, 1);
    pw(1, 0, 0);
    pw(1, 1, 1);
    pw(1, 0, 0);
    repeat (MaxOut) pw(0, 1, 0);
    chk32("pw_nack", 32'(nack), 32'd6);
    step(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);

    // abort with 3 outstanding, cyc reasserted while draining
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 1, 0, 0, 32'h400 + 32'(i), 32'h0);
      chk1("ab_acc_stall", s_stall, 1'b0);
    end
    step(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    chk1("ab_drop_stall", s_stall, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 1, 1, 0, 32'h500, 32'hB0 + 32'(i));
      chk1("ab_drain_stall", s_stall, 1'b1);
      chk1("ab_drain_req", s_req, 1'b0);
      chk1("ab_drain_ack", a_ack, 1'b0);
      chk1("ab_drain_err", a_err, 1'b0);
    end
    step(1, 1, 0, 1, 0, 0, 32'h600, 32'h0);
    chk1("ab_new_stall", s_stall, 1'b0);
    chk1("ab_new_req", s_req, 1'b1);
    step(1, 0, 0, 0, 1, 0, 32'h0, 32'hC0);
    chk1("ab_new_ack", a_ack, 1'b1);
    chk32("ab_new_dat", a_dat, 32'hC0);
    step(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);

    // spurious response
    chk1("sp_perr_pre", protocol_err, 1'b0);
    step(0, 0, 0, 0, 1, 0, 32'h0, 32'hEE);
    chk1("sp_perr", protocol_err, 1'b1);
    chk1("sp_ack", a_ack, 1'b0);
    repeat (2) step(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    chk1("sp_perr_sticky", protocol_err, 1'b1);
    probe_empty("sp_cnt");

    // reset with 2 outstanding and a live ack
    repeat (3) step(1, 1, 0, 1, 0, 0, 32'h700, 32'h0);
    step(1, 0, 0, 0, 1, 0, 32'h0, 32'hCAFE0001);
    chk1("rm_ack_pre", a_ack, 1'b1);
    rst_n = 0;
    #1;
    chk1("rm_ack", wb.ack, 1'b0);
    chk1("rm_err", wb.err, 1'b0);
    chk32("rm_dat", wb.dat_s, 32'h0);
    chk1("rm_perr", protocol_err, 1'b0);
    idle_inputs();
    @(posedge clk); #1 rst_n = 1;
    probe_empty("rm_cnt");

    // randomized run against an outstanding-count model
    do_reset();
    pend = 0; drn = 0; edat = '0;
    for (int n = 0; n < 400; n++) begin
      c  = ($urandom % 8) != 0;
      s  = c & (($urandom % 3) != 0);
      g  = 1'($urandom % 2);
      r  = (pend > 0) && (($urandom % 3) == 0);
      e  = ($urandom % 4) == 0;
      rd = $urandom;
      req = c & s & ~drn & (pend < MaxOut);
      acc = req & g;
      step(c, s, 1'($urandom % 2), g, r, e, $urandom, rd);
      chk1("rnd_stall", s_stall, (c & s) ? ~acc : drn);
      chk1("rnd_req", s_req, req);
      resp = r & ~drn & c;
      if (resp) edat = rd;
      chk1("rnd_ack", a_ack, resp & ~e);
      chk1("rnd_err", a_err, resp & e);
      chk32("rnd_dat", a_dat, edat);
      pend = pend + int'(acc) - int'(r);
      if (drn) drn = (pend != 0);
      else if (!c && pend != 0) drn = 1;
    end
    chk1("rnd_perr", protocol_err, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
